// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decode_pkg
//  Description : Shared widths, operand type codes and the decoded
//                instruction bundle for the instruction decode stage.
//  Revision    : 1.0 - initial release
// ============================================================================
package decode_pkg;

  localparam int OPCODE_W  = 6;
  localparam int ADDR_W    = 8;
  localparam int REG_SEL_W = 3;
  localparam int INSTR_W   = 2 + OPCODE_W + 3 * ADDR_W + 8;

  typedef enum logic [1:0] {
    OP_REG  = 2'b00,
    OP_MEM  = 2'b01,
    OP_IMM  = 2'b10,
    OP_RSVD = 2'b11
  } operand_type_e;

  typedef struct packed {
    logic [OPCODE_W-1:0]  opcode;
    logic [ADDR_W-1:0]    addr1;
    logic [ADDR_W-1:0]    addr2;
    logic [ADDR_W-1:0]    addr_out;
    operand_type_e        type1;
    operand_type_e        type2;
    operand_type_e        type_out;
    logic [REG_SEL_W-1:0] reg1;
    logic [REG_SEL_W-1:0] reg2;
    logic [REG_SEL_W-1:0] reg_out;
    logic [2:0]           reg_has_addr;
    logic [ADDR_W-1:0]    value;
    logic                 illegal;
  } decoded_t;

  // Reserved type anywhere, or an immediate destination, cannot execute.
  function automatic logic is_illegal(input operand_type_e t1,
                                      input operand_type_e t2,
                                      input operand_type_e t_out);
    return (t1 == OP_RSVD) || (t2 == OP_RSVD) ||
           (t_out == OP_RSVD) || (t_out == OP_IMM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/instruction_field_decode.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_field_decode
//  Description : Pure combinational split of a raw instruction word into the
//                decoded_t bundle. Optional illegal-encoding check enabled by
//                the DECODE_ILLEGAL_CHECK_EN macro.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_field_decode
  import decode_pkg::*;
(
  input  logic [INSTR_W-1:0] instruction,
  output decoded_t           decoded
);

  localparam int c_OP_MSB = INSTR_W - 3;
  localparam int c_A1_MSB = c_OP_MSB - OPCODE_W;
  localparam int c_A2_MSB = c_A1_MSB - ADDR_W;
  localparam int c_AO_MSB = c_A2_MSB - ADDR_W;

  // Bit 7 is a spare bit of the encoding and carries no meaning.
  logic w_unused_bit7;
  assign w_unused_bit7 = instruction[7];

  // Slice every field straight out of the word; register selects are the low address bits.
  always_comb begin
    decoded              = '0;
    decoded.opcode       = instruction[c_OP_MSB -: OPCODE_W];
    decoded.addr1        = instruction[c_A1_MSB -: ADDR_W];
    decoded.addr2        = instruction[c_A2_MSB -: ADDR_W];
    decoded.addr_out     = instruction[c_AO_MSB -: ADDR_W];
    decoded.type1        = operand_type_e'(instruction[5:4]);
    decoded.type2        = operand_type_e'(instruction[3:2]);
    decoded.type_out     = operand_type_e'(instruction[1:0]);
    decoded.reg1         = decoded.addr1[REG_SEL_W-1:0];
    decoded.reg2         = decoded.addr2[REG_SEL_W-1:0];
    decoded.reg_out      = decoded.addr_out[REG_SEL_W-1:0];
    decoded.reg_has_addr = {instruction[INSTR_W-1], instruction[INSTR_W-2], instruction[6]};
    decoded.value        = decoded.addr2;
`ifdef DECODE_ILLEGAL_CHECK_EN
    decoded.illegal      = is_illegal(decoded.type1, decoded.type2, decoded.type_out);
`else
    decoded.illegal      = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: rtl/instruction_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_decode_stage
//  Description : Registered, flow-controlled instruction decoder. Decoded
//                bundles are held in a main + skid entry pair so fetch and
//                execute stall independently. Optional macro:
//                DECODE_ILLEGAL_CHECK_EN (flags illegal type encodings).
//                The width parameters must match the decode_pkg widths that
//                size the stored bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_decode_stage
  import decode_pkg::*;
#(
  parameter int OPCODE_WIDTH  = OPCODE_W,
  parameter int ADDRESS_WIDTH = ADDR_W,
  parameter int REG_SEL_WIDTH = REG_SEL_W
)
(
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [2+OPCODE_WIDTH+3*ADDRESS_WIDTH+8-1:0] instruction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [OPCODE_WIDTH-1:0]       opCode,
  output logic [ADDRESS_WIDTH-1:0]      address1In,
  output logic [ADDRESS_WIDTH-1:0]      address2In,
  output logic [ADDRESS_WIDTH-1:0]      addressOut,
  output logic [1:0]                    address1Type,
  output logic [1:0]                    address2Type,
  output logic [1:0]                    outType,
  output logic [REG_SEL_WIDTH-1:0]      register1In,
  output logic [REG_SEL_WIDTH-1:0]      register2In,
  output logic [REG_SEL_WIDTH-1:0]      registerOut,
  output logic [2:0]                    registerHasAddress,
  output logic [ADDRESS_WIDTH-1:0]      instructionValue,
  output logic                          illegal
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

  state_e   r_state;
  state_e   w_state_next;
  logic     r_in_ready;
  decoded_t r_main;
  decoded_t r_skid;
  decoded_t w_decoded;
  decoded_t w_main_next;
  logic     w_accept;
  logic     w_drain;
  logic     w_load_main;
  logic     w_main_from_skid;
  logic     w_load_skid;

  instruction_field_decode u_field_decode (
    .instruction (instruction),
    .decoded     (w_decoded)
  );

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_state != ST_EMPTY);
  assign w_accept    = in_valid & r_in_ready;
  assign w_drain     = out_valid & out_ready;
  assign w_main_next = w_main_from_skid ? r_skid : w_decoded;

  // Skid FSM: decide the next occupancy and which entry is written this cycle.
  always_comb begin
    w_state_next     = r_state;
    w_load_main      = 1'b0;
    w_main_from_skid = 1'b0;
    w_load_skid      = 1'b0;
    if (flush) begin
      w_state_next = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_state_next = ST_ONE;
            w_load_main  = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_accept && w_drain) begin
            w_load_main = 1'b1;
          end else if (w_accept) begin
            w_state_next = ST_FULL;
            w_load_skid  = 1'b1;
          end else if (w_drain) begin
            w_state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_drain) begin
            w_state_next     = ST_ONE;
            w_load_main      = 1'b1;
            w_main_from_skid = 1'b1;
          end
        end
        default: w_state_next = ST_EMPTY;
      endcase
    end
  end

  // State, registered ready and entry storage; entries hold when not loaded.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= ST_EMPTY;
      r_in_ready <= 1'b1;
      r_main     <= '0;
      r_skid     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_in_ready <= (w_state_next != ST_FULL);
      if (w_load_main) r_main <= w_main_next;
      if (w_load_skid) r_skid <= w_decoded;
    end
  end

  assign opCode             = r_main.opcode;
  assign address1In         = r_main.addr1;
  assign address2In         = r_main.addr2;
  assign addressOut         = r_main.addr_out;
  assign address1Type       = r_main.type1;
  assign address2Type       = r_main.type2;
  assign outType            = r_main.type_out;
  assign register1In        = r_main.reg1;
  assign register2In        = r_main.reg2;
  assign registerOut        = r_main.reg_out;
  assign registerHasAddress = r_main.reg_has_addr;
  assign instructionValue   = r_main.value;
  assign illegal            = r_main.illegal;

endmodule
`default_nettype wire

// File: tb/tb_instruction_decode_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_instruction_decode_stage
//  Description : Self-checking bench for instruction_decode_stage: a queue
//                model of a 2-deep in-order buffer plus arithmetic field
//                extraction, with directed literal checks and random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_decode_stage;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [39:0] instruction;
  logic        out_valid;
  logic        out_ready;
  logic [5:0]  opCode;
  logic [7:0]  address1In, address2In, addressOut;
  logic [1:0]  address1Type, address2Type, outType;
  logic [2:0]  register1In, register2In, registerOut;
  logic [2:0]  registerHasAddress;
  logic [7:0]  instructionValue;
  logic        illegal;

  int total = 0;
  int bad   = 0;

  logic [39:0] q[$];
  logic [39:0] shown    = '0;
  bit          model_ok = 0;

`ifdef DECODE_ILLEGAL_CHECK_EN
  localparam bit CHECK_EN = 1'b1;
`else
  localparam bit CHECK_EN = 1'b0;
`endif

  instruction_decode_stage dut (
    .clock              (clk),
    .reset              (reset),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .instruction        (instruction),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .opCode             (opCode),
    .address1In         (address1In),
    .address2In         (address2In),
    .addressOut         (addressOut),
    .address1Type       (address1Type),
    .address2Type       (address2Type),
    .outType            (outType),
    .register1In        (register1In),
    .register2In        (register2In),
    .registerOut        (registerOut),
    .registerHasAddress (registerHasAddress),
    .instructionValue   (instructionValue),
    .illegal            (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build a word from its fields.
  function automatic logic [39:0] mk(input int top2, input int op, input int a1, input int a2,
                                     input int ao, input int b6, input int t1, input int t2,
                                     input int to);
    longint unsigned v;
    v = longint'(top2) * 64'h40_0000_0000 + longint'(op) * 64'h1_0000_0000 +
        longint'(a1) * 64'h100_0000 + longint'(a2) * 64'h1_0000 + longint'(ao) * 64'h100 +
        longint'(b6) * 64 + longint'(t1) * 16 + longint'(t2) * 4 + longint'(to);
    return v[39:0];
  endfunction

  // Expected output fields of a word, in DUT port order.
  function automatic logic [56:0] expect_fields(input logic [39:0] w);
    longint unsigned v;
    int op, a1, a2, ao, t1, t2, to, rha, ill;
    v   = 64'(w);
    op  = int'((v >> 32) % 64);
    a1  = int'((v >> 24) % 256);
    a2  = int'((v >> 16) % 256);
    ao  = int'((v >> 8) % 256);
    t1  = int'((v >> 4) % 4);
    t2  = int'((v >> 2) % 4);
    to  = int'(v % 4);
    rha = int'(((v >> 39) % 2) * 4 + ((v >> 38) % 2) * 2 + ((v >> 6) % 2));
    ill = (CHECK_EN && (t1 == 3 || t2 == 3 || to == 3 || to == 2)) ? 1 : 0;
    return {op[5:0], a1[7:0], a2[7:0], ao[7:0], t1[1:0], t2[1:0], to[1:0],
            a1[2:0], a2[2:0], ao[2:0], rha[2:0], a2[7:0], ill[0]};
  endfunction

  function automatic logic [56:0] dut_fields();
    return {opCode, address1In, address2In, addressOut, address1Type, address2Type, outType,
            register1In, register2In, registerOut, registerHasAddress, instructionValue, illegal};
  endfunction

  task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, got, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, then advance the model.
  task automatic step(input logic iv, input logic [39:0] w, input logic ordy,
                      input logic fl, input logic rs);
    bit acc, drn;
    @(posedge clk);
    #1;
    in_valid    = iv;
    instruction = w;
    out_ready   = ordy;
    flush       = fl;
    reset       = rs;
    @(negedge clk);
    if (model_ok) begin
      if (q.size() != 0) shown = q[0];
      cmp("out_valid", 64'(out_valid), 64'(q.size() != 0));
      cmp("in_ready", 64'(in_ready), 64'(q.size() < 2));
      cmp("fields", 64'(dut_fields()), 64'(expect_fields(shown)));
    end
    acc = iv && (q.size() < 2);
    drn = ordy && (q.size() != 0);
    if (rs) begin
      q.delete();
      shown    = '0;
      model_ok = 1;
    end else if (model_ok) begin
      if (fl) begin
        q.delete();
      end else begin
        if (drn) void'(q.pop_front());
        if (acc) q.push_back(w);
      end
    end
  endtask

  logic [39:0] wa, wb, wc, wd;
  logic [63:0] r64;

  initial begin
    in_valid    = 1'b0;
    instruction = '0;
    out_ready   = 1'b0;
    flush       = 1'b0;
    reset       = 1'b1;

    // Reset held two cycles.
    step(0, '0, 0, 0, 1);
    step(0, '0, 0, 0, 1);
    step(0, '0, 1, 0, 0);
    cmp("rst_out_valid", 64'(out_valid), 64'd0);
    cmp("rst_in_ready", 64'(in_ready), 64'd1);
    cmp("rst_fields", 64'(dut_fields()), 64'd0);

    // Single word, one-cycle latency, hand-computed fields.
    wa = mk(3, 'h2A, 'h11, 'h22, 'h33, 0, 0, 1, 2);
    step(1, wa, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    cmp("t2_opCode", 64'(opCode), 64'h2A);
    cmp("t2_address1In", 64'(address1In), 64'h11);
    cmp("t2_register2In", 64'(register2In), 64'd2);
    cmp("t2_instructionValue", 64'(instructionValue), 64'h22);
    cmp("t2_registerHasAddress", 64'(registerHasAddress), 64'b110);
    cmp("t2_addressOut", 64'(addressOut), 64'h33);

    // Back-pressure: third word held until the buffer drains.
    wa = mk(0, 'h01, 'hA1, 'hA2, 'hA3, 1, 0, 0, 1);
    wb = mk(1, 'h02, 'hB1, 'hB2, 'hB3, 0, 1, 1, 0);
    wc = mk(2, 'h03, 'hC1, 'hC2, 'hC3, 1, 1, 0, 1);
    step(1, wa, 0, 0, 0);
    step(1, wb, 0, 0, 0);
    step(1, wc, 0, 0, 0);
    cmp("t3_in_ready_low", 64'(in_ready), 64'd0);
    cmp("t3_head_opCode", 64'(opCode), 64'h01);
    step(1, wc, 1, 0, 0);
    step(1, wc, 1, 0, 0);
    cmp("t3_second_opCode", 64'(opCode), 64'h02);
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0);

    // Flush while full with a valid input in the same cycle.
    wd = mk(0, 'h3F, 'h44, 'h55, 'h66, 0, 0, 0, 0);
    step(1, wa, 0, 0, 0);
    step(1, wb, 0, 0, 0);
    step(1, wd, 0, 1, 0);
    step(0, '0, 1, 0, 0);
    cmp("t4_out_valid", 64'(out_valid), 64'd0);
    cmp("t4_in_ready", 64'(in_ready), 64'd1);
    step(0, '0, 1, 0, 0);

    // Illegal-encoding flag.
    step(1, mk(0, 5, 1, 2, 3, 0, 3, 0, 0), 1, 0, 0);
    step(1, mk(0, 6, 1, 2, 3, 0, 0, 0, 2), 1, 0, 0);
    cmp("t6_rsvd_type", 64'(illegal), 64'(CHECK_EN));
    step(1, mk(0, 7, 1, 2, 3, 0, 0, 1, 0), 1, 0, 0);
    cmp("t6_imm_dest", 64'(illegal), 64'(CHECK_EN));
    step(0, '0, 1, 0, 0);
    cmp("t6_legal", 64'(illegal), 64'd0);

    // Random traffic against the model.
    for (int i = 0; i < 10000; i++) begin
      r64 = {$urandom, $urandom};
      step($urandom_range(0, 3) != 0, r64[39:0],
           (i % 2000 < 1000) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0),
           $urandom_range(0, 63) == 0, $urandom_range(0, 1023) == 0);
    end
    for (int i = 0; i < 4; i++) step(0, '0, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
